mux_4_1_rr_sel: RTL and testbench



---
 rtl/mux_4_1_rr_sel_if.sv | 21 ++
 rtl/mux_4_1_rr_sel.sv | 107 ++++++++++
 tb/tb_mux_4_1_rr_sel.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_4_1_rr_sel_if.sv
// Request/select/handshake bundle between the four sources, the mux select
// sequencer and the consumer of the mux output.
interface mux_4_1_rr_sel_if;
    logic [3:0] req;
    logic       out_ready;
    logic       s0;
    logic       s1;
    logic [3:0] gnt;
    logic       out_valid;
    logic [3:0] ack;

    modport master (
        output req, out_ready,
        input  s0, s1, gnt, out_valid, ack
    );

    modport slave (
        input  req, out_ready,
        output s0, s1, gnt, out_valid, ack
    );
endinterface

// File: rtl/mux_4_1_rr_sel.sv
// Round-robin select sequencer for a 4x1 mux: grants one source at a time,
// holds the selects for the whole grant and caps each grant at HOLD beats.
module mux_4_1_rr_sel #(
    parameter int HOLD = 4,
    parameter int CW   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_4_1_rr_sel_if.slave bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

    state_t        state, state_nxt;
    logic [1:0]    cur, cur_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [1:0]    sel, sel_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    gnt, gnt_nxt;
    logic [1:0]    arb_base;
    logic          arb_ok;
    logic [1:0]    arb_win;
    logic          valid;
    logic          xfer;

    // Scan downward in offset so the lowest offset from base is the final winner.
    function automatic logic [2:0] arb(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // On release the new pointer (cur+1) is used in the same edge.
    assign arb_base          = (state == GRANT) ? cur + 2'd1 : ptr;
    assign {arb_ok, arb_win} = arb(bus.req, arb_base);

    assign valid = (state == GRANT) && bus.req[cur];
    assign xfer  = valid && bus.out_ready;

    assign bus.out_valid = valid;
    assign bus.ack       = xfer ? (4'b0001 << cur) : 4'b0000;
    assign bus.gnt       = gnt;
    assign bus.s0        = sel[0];
    assign bus.s1        = sel[1];

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        case (state)
            IDLE: begin
                if (arb_ok) begin
                    state_nxt = GRANT;
                    cur_nxt   = arb_win;
                    sel_nxt   = arb_win;
                    gnt_nxt   = 4'b0001 << arb_win;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (xfer) cnt_nxt = cnt + CW'(1);
                if (!bus.req[cur] || (xfer && cnt == HOLD_M1)) begin
                    ptr_nxt = cur + 2'd1;
                    if (arb_ok) begin
                        cur_nxt = arb_win;
                        sel_nxt = arb_win;
                        gnt_nxt = 4'b0001 << arb_win;
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= '0;
            ptr   <= '0;
            sel   <= '0;
            cnt   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
        end
    end

endmodule

// File: tb/tb_mux_4_1_rr_sel.sv
// Directed bench for mux_4_1_rr_sel: a round-robin model checked every cycle
// plus hand-computed expectations for the key scenarios.
module tb_mux_4_1_rr_sel;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    mux_4_1_rr_sel_if bus ();

    mux_4_1_rr_sel #(.HOLD(HOLD), .CW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: owner (-1 = idle), pointer, beats taken by current owner, last select.
    int m_own = -1;
    int m_ptr = 0;
    int m_beats = 0;
    int m_sel = 0;

    function automatic int find(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++)
            if (r[(start + i) % 4]) return (start + i) % 4;
        return -1;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = -1; m_ptr = 0; m_beats = 0; m_sel = 0;
        end else begin
            int w;
            bit rel;
            rel = 1'b0;
            if (m_own < 0) begin
                w = find(bus.req, m_ptr);
                if (w >= 0) begin m_own = w; m_sel = w; m_beats = 0; end
            end else begin
                if (bus.req[m_own] && bus.out_ready) begin
                    m_beats++;
                    if (m_beats == HOLD) rel = 1'b1;
                end
                if (!bus.req[m_own]) rel = 1'b1;
                if (rel) begin
                    m_ptr = (m_own + 1) % 4;
                    w = find(bus.req, m_ptr);
                    if (w >= 0) begin m_own = w; m_sel = w; m_beats = 0; end
                    else m_own = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] e_gnt, e_ack;
            logic       e_vld;
            e_gnt = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
            e_vld = (m_own >= 0) && bus.req[m_own];
            e_ack = (e_vld && bus.out_ready) ? e_gnt : 4'b0000;
            check("model_gnt", bus.gnt, e_gnt);
            check("model_valid", {3'b0, bus.out_valid}, {3'b0, e_vld});
            check("model_ack", bus.ack, e_ack);
            check("model_sel", {2'b0, bus.s1, bus.s0}, 4'(m_sel));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sel(input string name, input logic [1:0] exp);
        check(name, {2'b0, bus.s1, bus.s0}, {2'b0, exp});
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = 4'b0000;
        bus.out_ready = 1'b0;
        #2;
        check("reset_gnt", bus.gnt, 4'b0000);
        chk_sel("reset_sel", 2'b00);
        repeat (3) tick();
        rst_n = 1'b1;

        // All four requesting: 00,01,10,11,00 each for HOLD cycles.
        bus.req = 4'b1111;
        bus.out_ready = 1'b1;
        tick(); #2;
        for (int k = 0; k < 20; k++) begin
            chk_sel("rr_sel", 2'((k / 4) % 4));
            check("rr_gnt", bus.gnt, 4'b0001 << ((k / 4) % 4));
            check("rr_ack", bus.ack, 4'b0001 << ((k / 4) % 4));
            tick(); #2;
        end

        // Asynchronous reset mid-grant.
        rst_n = 1'b0;
        #1;
        check("arst_gnt", bus.gnt, 4'b0000);
        check("arst_ack", bus.ack, 4'b0000);
        check("arst_valid", {3'b0, bus.out_valid}, 4'b0000);
        chk_sel("arst_sel", 2'b00);
        tick();
        rst_n = 1'b1;
        tick(); #2;
        check("post_reset_gnt", bus.gnt, 4'b0001);
        chk_sel("post_reset_sel", 2'b00);

        // Drop to idle, selects hold.
        bus.req = 4'b0000;
        tick(); #2;
        check("idle_gnt", bus.gnt, 4'b0000);
        chk_sel("idle_sel_hold", 2'b00);

        // Single requester: continuous beats across re-grant.
        bus.req = 4'b0100;
        tick(); #2;
        check("single_gnt", bus.gnt, 4'b0100);
        chk_sel("single_sel", 2'b10);
        for (int k = 0; k < 8; k++) begin
            check("single_ack", bus.ack, 4'b0100);
            tick(); #2;
        end
        bus.req = 4'b0000;
        tick(); #2;
        chk_sel("idle_sel_hold2", 2'b10);

        // Backpressure on owner 1 after one beat.
        bus.req = 4'b0010;
        tick(); #2;
        check("bp_gnt", bus.gnt, 4'b0010);
        tick();
        bus.out_ready = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", {3'b0, bus.out_valid}, 4'b0001);
            check("bp_ack", bus.ack, 4'b0000);
            chk_sel("bp_sel", 2'b01);
            tick(); #2;
        end
        bus.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("bp_resume_ack", bus.ack, 4'b0010);
            tick(); #2;
        end
        bus.req = 4'b0000;
        tick(); #2;

        // Early withdrawal: owner 1 drops after 2 beats, 3 takes over.
        bus.req = 4'b0010;
        tick(); #2;
        check("wd_gnt1", bus.gnt, 4'b0010);
        bus.req = 4'b1010;
        tick(); tick();
        bus.req = 4'b1000;
        #2;
        check("wd_valid", {3'b0, bus.out_valid}, 4'b0000);
        tick(); #2;
        check("wd_gnt3", bus.gnt, 4'b1000);
        chk_sel("wd_sel", 2'b11);

        // Idle return, then priority starts after the old owner.
        bus.req = 4'b0000;
        tick(); #2;
        check("ir_gnt", bus.gnt, 4'b0000);
        check("ir_valid", {3'b0, bus.out_valid}, 4'b0000);
        chk_sel("ir_sel_hold", 2'b11);
        bus.req = 4'b0001;
        tick(); #2;
        check("ir_gnt0", bus.gnt, 4'b0001);
        bus.req = 4'b0000;
        tick(); #2;
        bus.req = 4'b1001;
        tick(); #2;
        check("prio_gnt3", bus.gnt, 4'b1000);

        // Request drops on what would be the HOLD-th beat.
        tick(); tick(); tick();
        bus.req = 4'b0001;
        #2;
        check("hold_drop_valid", {3'b0, bus.out_valid}, 4'b0000);
        tick(); #2;
        check("hold_drop_gnt", bus.gnt, 4'b0001);

        // Pseudo-random tail, checked by the model.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 2) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.req = 4'b0000;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
